// File: rtl/imm_encoder.sv
// imm_encoder: range-checks an immediate for its format and scatters it into an
// instruction template through a two-stage valid/ready pipeline.
module imm_encoder #(
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           immType,
    input  logic [31:0]          imm,
    input  logic [31:0]          inst_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          inst_out,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_count
);
    logic                 r_s1_valid, r_s1_err, r_s2_valid, r_s2_err;
    logic [2:0]           r_s1_type;
    logic [31:0]          r_s1_imm, r_s1_inst, r_s2_inst;
    logic [ERR_CNT_W-1:0] r_err_cnt;
    logic                 w_s1_load, w_s2_load, w_fit12, w_fit13, w_fit21, w_bad;
    logic [31:0]          w_pack;

    assign w_s2_load = !r_s2_valid || out_ready;
    assign w_s1_load = !r_s1_valid || w_s2_load;
    assign in_ready  = w_s1_load;
    assign out_valid = r_s2_valid;
    assign inst_out  = r_s2_inst;
    assign err       = r_s2_err;
    assign err_count = r_err_cnt;

    // Signed-fit tests: all bits above the field's sign bit must match it
    assign w_fit12 = &imm[31:11] || ~|imm[31:11];
    assign w_fit13 = &imm[31:12] || ~|imm[31:12];
    assign w_fit21 = &imm[31:20] || ~|imm[31:20];

    assign w_bad = (immType == 3'd0 || immType == 3'd2) ? !w_fit12 :
                   (immType == 3'd3) ? (!w_fit13 || imm[0]) :
                   (immType == 3'd5) ? (!w_fit21 || imm[0]) :
                   (immType == 3'd4) ? |imm[11:0] :
                   (immType == 3'd1) ? 1'b0 : 1'b1;

    assign w_pack = r_s1_err ? r_s1_inst :
        (r_s1_type == 3'd0) ? {r_s1_imm[11:0], r_s1_inst[19:0]} :
        (r_s1_type == 3'd2) ? {r_s1_imm[11:5], r_s1_inst[24:12], r_s1_imm[4:0], r_s1_inst[6:0]} :
        (r_s1_type == 3'd3) ? {r_s1_imm[12], r_s1_imm[10:5], r_s1_inst[24:12], r_s1_imm[4:1],
                               r_s1_imm[11], r_s1_inst[6:0]} :
        (r_s1_type == 3'd4) ? {r_s1_imm[31:12], r_s1_inst[11:0]} :
        (r_s1_type == 3'd5) ? {r_s1_imm[20], r_s1_imm[10:1], r_s1_imm[11], r_s1_imm[19:12],
                               r_s1_inst[11:0]} :
        r_s1_inst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s2_inst  <= '0;
            r_s2_err   <= 1'b0;
            r_err_cnt  <= '0;
        end else begin
            if (w_s1_load) begin
                r_s1_valid <= in_valid;
                r_s1_type  <= immType;
                r_s1_imm   <= imm;
                r_s1_inst  <= inst_in;
                r_s1_err   <= w_bad;
            end
            if (w_s2_load) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_inst <= w_pack;
                    r_s2_err  <= r_s1_err;
                end
            end
            if (r_s2_valid && out_ready && r_s2_err && !(&r_err_cnt))
                r_err_cnt <= r_err_cnt + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
        end
    end
endmodule
